pbit_group_scheduler: RTL and testbench
=======================================

# pbit_group_scheduler

Sequencer for the graph-colored p-bit network. It drives the 3-bit `group_EN` select of the grouped update-order LUT, stepping through colour groups 0..NUM_GROUPS-1 one slot at a time. Each slot is one update-enable cycle followed by a programmable settle interval. The block counts full sweeps, strobes a sample point after each sweep, and reports completion through a start/done handshake. Downstream logic ANDs the LUT's `Pbit_EN` with `update_en`, so p-bits flip only in update cycles.

## Interface
Parameters:
- NUM_GROUPS, 4, number of colour groups; legal 1..8; `group_EN` only ever carries 0..NUM_GROUPS-1
- SWEEP_W, 16, width of sweep count and sweep target
- SETTLE_W, 8, width of settle-cycle count

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- stop  in  1  request early end; takes effect at the next sweep boundary
- pause  in  1  freeze sequencing while high
- num_sweeps  in  SWEEP_W  sweep target; latched on accepted start
- settle_cycles  in  SETTLE_W  idle cycles after each update cycle; latched on accepted start
- group_EN  out  3  current colour group, to the LUT select
- update_en  out  1  p-bit update strobe for the selected group
- sweep_done  out  1  one-cycle pulse when a sweep completes
- sweep_count  out  SWEEP_W  number of completed sweeps in the current or last run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

## Operation
- All outputs are registered.
- Reset values: `group_EN`=0, `update_en`=0, `sweep_done`=0, `sweep_count`=0, `busy`=0, `done`=0, state=IDLE, stop_pending=0.
- States: IDLE, UPD, SETTLE, DONE.
- **IDLE**
  - `start`=1 latches `num_sweeps` as N and `settle_cycles` as S.
  - Clears `sweep_count` and sets `group_EN`=0.
  - N=0: go to DONE. Otherwise go to UPD.
- **UPD** (exactly one cycle, `update_en`=1)
  - S=0: advance immediately.
  - S>0: go to SETTLE with the settle counter loaded to S.
- **SETTLE**
  - `update_en`=0; the counter decrements each cycle.
  - On the last settle cycle, advance.
- **Advance**
  - If `group_EN` is not the last group: increment `group_EN` and go to UPD.
  - If `group_EN` is the last group:
    - set `group_EN`=0, increment `sweep_count`, pulse `sweep_done`;
    - if the new count equals N, or stop_pending=1, go to DONE;
    - otherwise go to UPD.
- **DONE**
  - `done`=1 and `busy`=0 for one cycle, then IDLE.
  - `group_EN` stays 0; `sweep_count` holds its final value until the next start.
- **stop**
  - Sets stop_pending while busy; cleared in DONE.
  - The current sweep always completes, so samples are never from a partial sweep.
- **pause**
  - High in UPD or SETTLE: freezes state, counters and `group_EN`, and forces `update_en`=0.
  - A frozen UPD reissues its update cycle after `pause` falls.
  - Ignored in IDLE and DONE.
- `start` is ignored while `busy` or in DONE.
- Reset mid-run aborts immediately to reset values; there is no done pulse.
- `sweep_count` saturates at all-ones; it cannot exceed N.

## Timing
- Cycle numbering: cycle 0 is the edge that samples `start`=1. G = NUM_GROUPS, slot length L = S+1.
- Sweep k, group g: `update_en`=1 during cycle 1 + (k·G + g)·L, with `group_EN`=g.
- `busy`: high in cycles 1 .. N·G·L, then low.
- `sweep_done` and the `sweep_count` increment: visible in cycle (k+1)·G·L + 1. This coincides with the next sweep's group-0 update cycle; the sampled state is that of the completed sweep.
- `done`: cycle N·G·L + 1, with `busy`=0. A new `start` is accepted from cycle N·G·L + 2.
- N=0: `done` in cycle 1; no update cycles.
- Each pause cycle delays all later events by one cycle.

## Test plan
- G=4, S=2, N=3, start at cycle 0:
  - `update_en` at cycles 1,4,7,…,34, with `group_EN` cycling 0,1,2,3;
  - `sweep_done` at 13, 25, 37;
  - `done` at 37 with `sweep_count`=3; `busy` high 1..36.
- S=0, N=2: `update_en` high continuously for cycles 1..8, `group_EN` 0,1,2,3,0,1,2,3; `done` at 9.
- N=0: `done` at cycle 1, `update_en` never high, `sweep_count`=0; `start` pulsed in cycle 1 is ignored.
- G=4, S=1, N=5, `stop` pulsed at cycle 10:
  - sweep 0 completes normally (`sweep_done` at cycle 9);
  - the run completes the current sweep 1, `sweep_done` at 17;
  - `done` at 17 with `sweep_count`=2.
- `pause` high during cycles 4..6 of a run with S=2: the update due at cycle 4 moves to cycle 7, and all later events shift by 3; `group_EN` is held during the pause.
- `rst_n` asserted asynchronously mid-SETTLE: all outputs read 0 immediately; after release, a fresh start reruns the first test's timing exactly.

Source files
------------

// File: rtl/pbit_group_scheduler.sv
// rtl/pbit_group_scheduler.sv - colour-group update sequencer for a graph-coloured p-bit network
//
// Steps group_EN through colour groups 0..NUM_GROUPS-1. Each slot is one
// update_en cycle followed by settle_cycles idle cycles. Counts full sweeps,
// pulses sweep_done at every sweep boundary and pulses done at end of run.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a run (sampled only in IDLE)
//   stop            end the run at the next sweep boundary
//   pause           freeze sequencing while high (UPD/SETTLE only)
//   num_sweeps      sweep target N, latched on accepted start
//   settle_cycles   settle length S, latched on accepted start
//   group_EN        current colour group to the LUT select
//   update_en       p-bit update strobe for the selected group
//   sweep_done      one-cycle pulse per completed sweep
//   sweep_count     completed sweeps in the current or last run
//   busy            run in progress
//   done            one-cycle pulse at end of run
module pbit_group_scheduler #(
    parameter int NUM_GROUPS = 4,
    parameter int SWEEP_W    = 16,
    parameter int SETTLE_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic [SWEEP_W-1:0]  num_sweeps,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [2:0]          group_EN,
    output logic                update_en,
    output logic                sweep_done,
    output logic [SWEEP_W-1:0]  sweep_count,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPD,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_GROUP = 3'(NUM_GROUPS - 1);

    state_t              r_state;
    logic [SWEEP_W-1:0]  r_num_sweeps;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [2:0]          r_group;
    logic                r_update_en;
    logic                r_sweep_done;
    logic [SWEEP_W-1:0]  r_sweep_count;
    logic                r_busy;
    logic                r_done;
    logic                r_stop_pending;

    logic                w_advance;
    logic                w_last_group;
    logic [SWEEP_W-1:0]  w_count_inc;
    logic                w_run_end;

    // A slot ends either straight out of a completed update cycle (S=0) or on
    // the last settle cycle. r_update_en low in UPD means the update was
    // frozen by pause and still has to be reissued, so no advance yet.
    assign w_advance = !pause &&
                       (((r_state == S_UPD) && r_update_en && (r_settle == '0)) ||
                        ((r_state == S_SETTLE) && (r_settle_cnt <= SETTLE_W'(1))));

    assign w_last_group = (r_group == LAST_GROUP);
    assign w_count_inc  = (&r_sweep_count) ? r_sweep_count : r_sweep_count + SWEEP_W'(1);
    assign w_run_end    = (w_count_inc == r_num_sweeps) || r_stop_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_num_sweeps   <= '0;
            r_settle       <= '0;
            r_settle_cnt   <= '0;
            r_group        <= '0;
            r_update_en    <= 1'b0;
            r_sweep_done   <= 1'b0;
            r_sweep_count  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_stop_pending <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            r_done       <= 1'b0;
            if (r_busy && stop) begin
                r_stop_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_sweeps  <= num_sweeps;
                        r_settle      <= settle_cycles;
                        r_sweep_count <= '0;
                        r_group       <= '0;
                        if (num_sweeps == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_UPD;
                            r_update_en <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_UPD: begin
                    if (pause) begin
                        r_update_en <= 1'b0;
                    end else if (!r_update_en) begin
                        // reissue the update cycle that pause suppressed
                        r_update_en <= 1'b1;
                    end else if (r_settle != '0) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= r_settle;
                        r_update_en  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (!pause && !w_advance) begin
                        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                    end
                end
                S_DONE: begin
                    r_state        <= S_IDLE;
                    r_stop_pending <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                if (!w_last_group) begin
                    r_group     <= r_group + 3'd1;
                    r_state     <= S_UPD;
                    r_update_en <= 1'b1;
                end else begin
                    r_group       <= '0;
                    r_sweep_count <= w_count_inc;
                    r_sweep_done  <= 1'b1;
                    if (w_run_end) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_update_en <= 1'b0;
                    end else begin
                        r_state     <= S_UPD;
                        r_update_en <= 1'b1;
                    end
                end
            end
        end
    end

    assign group_EN    = r_group;
    assign update_en   = r_update_en;
    assign sweep_done  = r_sweep_done;
    assign sweep_count = r_sweep_count;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_pbit_group_scheduler.sv
// tb/tb_pbit_group_scheduler.sv - self-checking bench for pbit_group_scheduler
module tb_pbit_group_scheduler;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] num_sweeps = '0;
    logic [7:0]  settle_cycles = '0;
    logic [2:0]  group_EN;
    logic        update_en;
    logic        sweep_done;
    logic [15:0] sweep_count;
    logic        busy;
    logic        done;

    pbit_group_scheduler #(.NUM_GROUPS(G), .SWEEP_W(16), .SETTLE_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .num_sweeps   (num_sweeps),
        .settle_cycles(settle_cycles),
        .group_EN     (group_EN),
        .update_en    (update_en),
        .sweep_done   (sweep_done),
        .sweep_count  (sweep_count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  grp;
        logic        upd;
        logic        sd;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
    } obs_t;

    // n/s: run setup; stop_c: cycle whose edge sees stop (-1 none);
    // pause_c/pause_len: pause seen by edges pause_c..pause_c+len-1 (-1 none);
    // exp_done/exp_count: required done cycle and final sweep_count.
    typedef struct {
        int n;
        int s;
        int stop_c;
        int pause_c;
        int pause_len;
        int exp_done;
        int exp_count;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    obs_t exp_q[$];
    vec_t vecs[6];

    function automatic obs_t exp_at(int e, int n, int s);
        obs_t r;
        int l  = s + 1;
        int gl = G * l;
        int t  = n * gl;
        int k;
        r.busy = (e >= 1) && (e <= t);
        r.done = (e == t + 1);
        r.upd  = r.busy && ((e - 1) % l == 0);
        r.grp  = r.busy ? 3'(((e - 1) / l) % G) : 3'd0;
        r.sd   = (e >= gl + 1) && (e <= t + 1) && ((e - 1) % gl == 0);
        k      = (e < 1) ? 0 : (e - 1) / gl;
        r.cnt  = 16'((k > n) ? n : k);
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.grp  = group_EN;
        o.upd  = update_en;
        o.sd   = sweep_done;
        o.cnt  = sweep_count;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    task automatic check_obs(string name, int c, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got grp=%0d upd=%0b sd=%0b cnt=%0d busy=%0b done=%0b, expected grp=%0d upd=%0b sd=%0b cnt=%0d busy=%0b done=%0b",
                     name, c, act.grp, act.upd, act.sd, act.cnt, act.busy, act.done,
                     exp.grp, exp.upd, exp.sd, exp.cnt, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(int idx);
        vec_t v = vecs[idx];
        int l = v.s + 1;
        int gl = G * l;
        int n_eff = v.n;
        int plen = (v.pause_c >= 0) ? v.pause_len : 0;
        int last;
        int done_seen = -1;
        int cnt_at_done = -1;
        obs_t e;
        string name;

        if (v.stop_c >= 0 && (v.stop_c / gl + 1) < n_eff) n_eff = v.stop_c / gl + 1;
        last = n_eff * gl + plen + 2;
        name = $sformatf("trace[v%0d]", idx);

        for (int c = 1; c <= last; c++) begin
            if (plen == 0 || c <= v.pause_c) begin
                e = exp_at(c, n_eff, v.s);
            end else if (c <= v.pause_c + plen) begin
                e = exp_at(v.pause_c, n_eff, v.s);
                e.upd = 1'b0;
                e.sd = 1'b0;
                e.done = 1'b0;
            end else begin
                e = exp_at(c - plen, n_eff, v.s);
            end
            exp_q.push_back(e);
        end

        start = 1'b1;
        num_sweeps = 16'(v.n);
        settle_cycles = 8'(v.s);
        stop = 1'b0;
        pause = 1'b0;
        @(posedge clk);
        #1;
        // values after the accepting edge must not matter
        num_sweeps = 16'($urandom);
        settle_cycles = 8'($urandom);

        for (int c = 1; c <= last; c++) begin
            check_obs(name, c, sample(), exp_q.pop_front());
            if (done && done_seen < 0) begin
                done_seen = c;
                cnt_at_done = int'(sweep_count);
            end
            start = (c == 1);
            stop = (c == v.stop_c);
            pause = (v.pause_c >= 0) && (c >= v.pause_c) && (c < v.pause_c + v.pause_len);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        check_int($sformatf("done_cycle[v%0d]", idx), done_seen, v.exp_done);
        check_int($sformatf("final_count[v%0d]", idx), cnt_at_done, v.exp_count);
    endtask

    initial begin
        vecs[0] = '{n: 3, s: 2, stop_c: -1, pause_c: -1, pause_len: 0, exp_done: 37, exp_count: 3};
        vecs[1] = '{n: 2, s: 0, stop_c: -1, pause_c: -1, pause_len: 0, exp_done: 9,  exp_count: 2};
        vecs[2] = '{n: 0, s: 2, stop_c: -1, pause_c: -1, pause_len: 0, exp_done: 1,  exp_count: 0};
        vecs[3] = '{n: 5, s: 1, stop_c: 10, pause_c: -1, pause_len: 0, exp_done: 17, exp_count: 2};
        // pause seen by edges 3..5 blanks cycles 4..6; the update due at 4 lands at 7
        vecs[4] = '{n: 3, s: 2, stop_c: -1, pause_c: 3,  pause_len: 3, exp_done: 40, exp_count: 3};
        vecs[5] = '{n: 1, s: 3, stop_c: -1, pause_c: -1, pause_len: 0, exp_done: 17, exp_count: 1};

        repeat (2) @(posedge clk);
        #1;
        check_obs("reset_state", 0, sample(), obs_t'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            @(posedge clk);
            #1;
        end

        // asynchronous reset in the middle of a settle interval
        start = 1'b1;
        num_sweeps = 16'd3;
        settle_cycles = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_obs("pre_reset_settle", 2, sample(), exp_at(2, 3, 2));
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("async_reset", 2, sample(), obs_t'(0));
        @(posedge clk);
        #1;
        check_obs("held_reset", 3, sample(), obs_t'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
